// File: rtl/vga_reg_pkg.sv
// Shared types and register map for the VGA sprite/score register writer.
package vga_reg_pkg;

    typedef enum logic {WAIT, FLUSH} state_t;

    localparam int VGA_ADDR_W = 9;
    localparam int VGA_DATA_W = 32;

    localparam logic [VGA_ADDR_W-1:0] REG_DINO_X  = 9'd0;
    localparam logic [VGA_ADDR_W-1:0] REG_DINO_Y  = 9'd1;
    localparam logic [VGA_ADDR_W-1:0] REG_JUMP_X  = 9'd2;
    localparam logic [VGA_ADDR_W-1:0] REG_JUMP_Y  = 9'd3;
    localparam logic [VGA_ADDR_W-1:0] REG_DUCK_X  = 9'd4;
    localparam logic [VGA_ADDR_W-1:0] REG_DUCK_Y  = 9'd5;
    localparam logic [VGA_ADDR_W-1:0] REG_SCAC_X  = 9'd6;
    localparam logic [VGA_ADDR_W-1:0] REG_SCAC_Y  = 9'd7;
    localparam logic [VGA_ADDR_W-1:0] REG_GODZ_X  = 9'd8;
    localparam logic [VGA_ADDR_W-1:0] REG_GODZ_Y  = 9'd9;
    localparam logic [VGA_ADDR_W-1:0] REG_SCORE_X = 9'd10;
    localparam logic [VGA_ADDR_W-1:0] REG_SCORE_Y = 9'd11;

    typedef struct packed {
        logic [VGA_ADDR_W-1:0] addr;
        logic [VGA_DATA_W-1:0] data;
    } reg_wr_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// Synchronous FIFO of register updates; head is read combinationally (no look-ahead).
module reg_wr_fifo
    import vga_reg_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  reg_wr_t          push_data,
    input  logic             pop,
    output reg_wr_t          head,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    reg_wr_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    assign head = mem[rd_ptr];
    assign full = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/vga_reg_writer.sv
// Replays buffered sprite/score register updates onto the VGA register bus.
// VGA_REG_WRITER_VSYNC_GATE_EN: start each flush at the VGA_VS falling edge instead of immediately.
module vga_reg_writer
    import vga_reg_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = VGA_ADDR_W,
    parameter  int DATA_W = VGA_DATA_W,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              VGA_VS,
    output logic              chipselect,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic [LVL_W-1:0]  level,
    output logic              busy,
    output logic              frame_done
);

    state_t           state, state_nx;
    logic [LVL_W-1:0] remaining, remaining_nx;
    logic             full, push, pop, last_pop, start;
    logic             done_p1;
    reg_wr_t          push_ent, head;

    assign req_ready     = !full;
    assign push          = req_valid && req_ready;
    assign push_ent.addr = VGA_ADDR_W'(req_addr);
    assign push_ent.data = VGA_DATA_W'(req_data);

    reg_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .level     (level)
    );

`ifdef VGA_REG_WRITER_VSYNC_GATE_EN
    logic vs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vs_q <= 1'b1;
        else          vs_q <= VGA_VS;
    end

    assign start = vs_q && !VGA_VS && (level != '0);
`else
    logic unused_vs;
    assign unused_vs = VGA_VS;
    assign start     = (level != '0);
`endif

    // Entries pushed during a flush are excluded: remaining is latched at start.
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        pop          = 1'b0;
        last_pop     = 1'b0;
        case (state)
            WAIT: begin
                if (start) begin
                    state_nx     = FLUSH;
                    remaining_nx = level;
                end
            end
            FLUSH: begin
                pop          = 1'b1;
                remaining_nx = remaining - 1'b1;
                if (remaining == LVL_W'(1)) begin
                    last_pop = 1'b1;
                    state_nx = WAIT;
                end
            end
            default: state_nx = WAIT;
        endcase
    end

    // Stage p0 -> bus register: popped head appears on the bus one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT;
            remaining  <= '0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            busy       <= 1'b0;
            done_p1    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            write      <= pop;
            busy       <= (state_nx == FLUSH) || pop;
            done_p1    <= last_pop;
            frame_done <= done_p1;
            if (pop) begin
                address   <= ADDR_W'(head.addr);
                writedata <= DATA_W'(head.data);
            end
        end
    end

    assign chipselect = write;

endmodule

// File: tb/tb_vga_reg_writer.sv
// Scoreboard bench for vga_reg_writer; covers gated or ungated build via the same macro.
module tb_vga_reg_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        VGA_VS = 1'b1;
    logic        chipselect, write, busy, frame_done;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic [4:0]  level;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          nwr = 0;
    logic [40:0] sb[$];
    logic [40:0] exp_e;

    vga_reg_writer #(.DEPTH(16), .ADDR_W(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .VGA_VS     (VGA_VS),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .level      (level),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every bus write is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (write) begin
            nwr++;
            chk("chipselect", 64'(chipselect), 64'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", address, writedata);
            end else begin
                exp_e = sb.pop_front();
                chk("wr_addr", 64'(address), 64'(exp_e[40:32]));
                chk("wr_data", 64'(writedata), 64'(exp_e[31:0]));
            end
        end
    end

    task automatic push(input logic [8:0] a, input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual ready=0 required ready=1");
            req_valid = 1'b0;
        end else begin
            sb.push_back({a, d});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Flush started in cycle n with k entries: busy n+1..n+k+1, write n+2..n+k+1, frame_done n+k+2.
    task automatic check_flush(input int n, input int k);
        while (cyc < n + 1) @(negedge clk);
        for (int c = n + 1; c <= n + k + 2; c++) begin
            chk("flush_write", 64'(write), 64'(c >= n + 2 && c <= n + k + 1));
            chk("flush_busy", 64'(busy), 64'(c <= n + k + 1));
            chk("flush_frame_done", 64'(frame_done), 64'(c == n + k + 2));
            if (c < n + k + 2) @(negedge clk);
        end
    endtask

    task automatic wait_writes(input int target);
        int t = 0;
        while (nwr < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("wait_writes", 64'(nwr >= target), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n;
        int base;
        repeat (3) @(negedge clk);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_chipselect", 64'(chipselect), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_writedata", 64'(writedata), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef VGA_REG_WRITER_VSYNC_GATE_EN
        push(9'd0, 32'd50);
        push(9'd1, 32'd60);
        push(9'd10, 32'd200);
        idle();
        repeat (2) @(negedge clk);
        chk("pre_vs_level", 64'(level), 64'd3);
        chk("pre_vs_busy", 64'(busy), 64'd0);
        chk("pre_vs_write", 64'(write), 64'd0);
        @(negedge clk);
        VGA_VS = 1'b0;
        n = cyc;
        check_flush(n, 3);
        chk("post_flush_level", 64'(level), 64'd0);
        @(negedge clk);
        VGA_VS = 1'b1;

        for (int i = 0; i < 16; i++) push(9'(i % 12), 32'(1000 + i));
        idle();
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_level", 64'(level), 64'd16);
        fork
            begin
                push(9'd11, 32'hABCD);
                @(negedge clk);
                req_valid = 1'b0;
                chk("level_push_pop", 64'(level), 64'd15);
            end
            begin
                int nb;
                repeat (3) @(negedge clk);
                VGA_VS = 1'b0;
                nb = cyc;
                check_flush(nb, 16);
            end
        join
        chk("held_level", 64'(level), 64'd1);
        @(negedge clk);
        VGA_VS = 1'b1;
        repeat (2) @(negedge clk);
        VGA_VS = 1'b0;
        n = cyc;
        check_flush(n, 1);
        @(negedge clk);
        VGA_VS = 1'b1;
`else
        push(9'd8, 32'd100);
        n = cyc;
        idle();
        check_flush(n + 1, 1);
        chk("single_level", 64'(level), 64'd0);

        VGA_VS = 1'b0;
        push(9'd0, 32'd50);
        push(9'd1, 32'd60);
        push(9'd10, 32'd200);
        idle();
        drain();
        chk("burst_level", 64'(level), 64'd0);
        VGA_VS = 1'b1;
`endif

        // Falling VGA_VS with an empty FIFO must not start a flush.
        @(negedge clk);
        VGA_VS = 1'b1;
        @(negedge clk);
        VGA_VS = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("empty_write", 64'(write), 64'd0);
            chk("empty_busy", 64'(busy), 64'd0);
            chk("empty_frame_done", 64'(frame_done), 64'd0);
        end
        VGA_VS = 1'b1;
        repeat (2) @(negedge clk);

        base = nwr;
        for (int i = 0; i < 5; i++) push(9'(i), 32'(500 + i));
        idle();
`ifdef VGA_REG_WRITER_VSYNC_GATE_EN
        @(negedge clk);
        VGA_VS = 1'b0;
`endif
        wait_writes(base + 2);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_write", 64'(write), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_frame_done", 64'(frame_done), 64'd0);
        sb.delete();
        VGA_VS = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = nwr;
        repeat (2) @(negedge clk);
        VGA_VS = 1'b0;
        @(negedge clk);
        VGA_VS = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_writes", 64'(nwr), 64'(base));
        chk("post_rst_level", 64'(level), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
